// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency
// results bypass or wait in a small FIFO, and a scoreboard drives the decode stall.
module rf_wb_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        lu_valid,
  input  logic [4:0]  lu_waddr,
  input  logic [31:0] lu_wdata,
  output logic        lu_ready,
  input  logic        issue_set,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  input  logic [4:0]  chk_rd,
  output logic        stall,
  output logic [31:0] busy,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_din
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  typedef enum logic [1:0] {SRC_NONE, SRC_PIPE, SRC_FIFO, SRC_BYPASS} src_e;

  wb_t            mem [FIFO_DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [AW:0]    count;
  logic [31:0]    busy_next;
  src_e           src;

  logic full, empty, pipe_act, lu_acc, lu_nz, push, pop, lu_wr;
  logic [4:0] lu_wr_addr;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign lu_ready = rstn & ~full;
  assign pipe_act = pipe_we & (pipe_waddr != 5'd0);
  assign lu_acc   = lu_valid & lu_ready;
  assign lu_nz    = lu_acc & (lu_waddr != 5'd0);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    src = SRC_NONE;
    if (rstn) begin
      if (pipe_act)    src = SRC_PIPE;
      else if (!empty) src = SRC_FIFO;
      else if (lu_nz)  src = SRC_BYPASS;
    end
  end

  assign pop  = (src == SRC_FIFO);
  assign push = lu_nz & (src != SRC_BYPASS);

  always_comb begin
    rf_we      = 1'b0;
    rf_waddr   = 5'd0;
    rf_din     = 32'd0;
    lu_wr      = 1'b0;
    lu_wr_addr = 5'd0;
    unique case (src)
      SRC_PIPE: begin
        rf_we    = 1'b1;
        rf_waddr = pipe_waddr;
        rf_din   = pipe_wdata;
      end
      SRC_FIFO: begin
        rf_we      = 1'b1;
        rf_waddr   = mem[rd_ptr].addr;
        rf_din     = mem[rd_ptr].data;
        lu_wr      = 1'b1;
        lu_wr_addr = mem[rd_ptr].addr;
      end
      SRC_BYPASS: begin
        rf_we      = 1'b1;
        rf_waddr   = lu_waddr;
        rf_din     = lu_wdata;
        lu_wr      = 1'b1;
        lu_wr_addr = lu_waddr;
      end
      default: ;
    endcase
  end

  // A same-cycle issue to the register being drained must leave it busy, so set follows clear.
  always_comb begin
    busy_next = busy;
    if (lu_wr)     busy_next[lu_wr_addr] = 1'b0;
    if (issue_set) busy_next[issue_rd]   = 1'b1;
    busy_next[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      busy   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      busy  <= busy_next;
    end
  end

  // NOTE: FIFO storage is not reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: lu_waddr, data: lu_wdata};
  end

  assign stall = rstn & (busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd]);

  // A pipeline write must never target a register with an outstanding long-latency result.
  assert property (@(posedge clk) disable iff (!rstn) !(pipe_act && busy[pipe_waddr]));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios followed by random
// traffic compared against a queue-based model of the write-port rules.
module tb_rf_wb_arbiter;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        pipe_we, lu_valid, issue_set;
  logic [4:0]  pipe_waddr, lu_waddr, issue_rd, chk_rs1, chk_rs2, chk_rd;
  logic [31:0] pipe_wdata, lu_wdata;
  logic        lu_ready, stall, rf_we;
  logic [31:0] busy, rf_din;
  logic [4:0]  rf_waddr;

  int checks = 0;
  int errors = 0;

  rf_wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .lu_valid(lu_valid), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata), .lu_ready(lu_ready),
    .issue_set(issue_set), .issue_rd(issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .stall(stall), .busy(busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_din(rf_din)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0;
    lu_valid = 0; lu_waddr = 0; lu_wdata = 0;
    issue_set = 0; issue_rd = 0;
    chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
  endtask

  task automatic test_reset();
    idle();
    rstn = 1'b0;
    pipe_we = 1; pipe_waddr = 5'd3; pipe_wdata = 32'h1234;
    lu_valid = 1; lu_waddr = 5'd6;
    #2;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %0b want 0", rf_we); end
    checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL reset_lu_ready: got %0b want 0", lu_ready); end
    checks++; if (rf_waddr !== 5'd0 || rf_din !== 32'd0) begin errors++; $display("FAIL reset_rf_bus: got %0d/%h want 0/0", rf_waddr, rf_din); end
    step();
    checks++; if (busy !== 32'd0 || stall !== 1'b0) begin errors++; $display("FAIL reset_busy: got %h/%0b want 0/0", busy, stall); end
    idle();
    @(negedge clk);
    rstn = 1'b1;
    step();
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b want 1", lu_ready); end
  endtask

  task automatic test_bypass();
    issue_set = 1; issue_rd = 5'd5; chk_rs1 = 5'd5;
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bypass_stall_pre: got %0b want 0", stall); end
    step();
    issue_set = 0;
    #1;
    checks++; if (busy[5] !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL bypass_busy_set: got %0b/%0b want 1/1", busy[5], stall); end
    lu_valid = 1; lu_waddr = 5'd5; lu_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_din !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_write: got %0b/%0d/%h want 1/5/deadbeef", rf_we, rf_waddr, rf_din); end
    step();
    idle(); chk_rs1 = 5'd5;
    #1;
    checks++; if (busy[5] !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL bypass_busy_clr: got %0b/%0b want 0/0", busy[5], stall); end
    idle();
  endtask

  task automatic test_conflict();
    pipe_we = 1; pipe_waddr = 5'd3; pipe_wdata = 32'h11;
    lu_valid = 1; lu_waddr = 5'd7; lu_wdata = 32'h22;
    #2;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_din !== 32'h11) begin errors++; $display("FAIL conflict_c0: got %0b/%0d/%h want 1/3/11", rf_we, rf_waddr, rf_din); end
    step();
    idle();
    #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_din !== 32'h22) begin errors++; $display("FAIL conflict_c1: got %0b/%0d/%h want 1/7/22", rf_we, rf_waddr, rf_din); end
    step();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL conflict_c2: got %0b want 0", rf_we); end
  endtask

  task automatic test_full();
    logic [4:0]  exp_a [3];
    logic [31:0] exp_d [3];
    exp_a = '{5'd10, 5'd11, 5'd12};
    exp_d = '{32'hA, 32'hB, 32'hC};
    pipe_we = 1; pipe_waddr = 5'd1; pipe_wdata = 32'h100;
    for (int c = 0; c < 4; c++) begin
      lu_valid = 1; lu_waddr = exp_a[(c < 2) ? c : 2]; lu_wdata = exp_d[(c < 2) ? c : 2];
      #1;
      checks++; if (lu_ready !== (c < 2)) begin errors++; $display("FAIL full_ready_c%0d: got %0b want %0b", c, lu_ready, c < 2); end
      checks++; if (rf_waddr !== 5'd1) begin errors++; $display("FAIL full_pipe_c%0d: got %0d want 1", c, rf_waddr); end
      step();
    end
    pipe_we = 0;
    #1;
    checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_no_comb_rise: got %0b want 0", lu_ready); end
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (rf_we !== 1'b1 || rf_waddr !== exp_a[i] || rf_din !== exp_d[i]) begin errors++; $display("FAIL full_drain_%0d: got %0b/%0d/%h want 1/%0d/%h", i, rf_we, rf_waddr, rf_din, exp_a[i], exp_d[i]); end
      if (i == 1) begin
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL full_c_accept: got %0b want 1", lu_ready); end
      end
      step();
      if (i == 1) lu_valid = 0;
    end
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL full_empty: got %0b want 0", rf_we); end
    idle();
  endtask

  task automatic test_x0();
    pipe_we = 1; pipe_waddr = 5'd0; pipe_wdata = 32'h55;
    lu_valid = 1; lu_waddr = 5'd9; lu_wdata = 32'h99;
    #2;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_din !== 32'h99) begin errors++; $display("FAIL x0_bypass: got %0b/%0d/%h want 1/9/99", rf_we, rf_waddr, rf_din); end
    step();
    idle();
    lu_valid = 1; lu_waddr = 5'd0; lu_wdata = 32'h77;
    #1;
    checks++; if (lu_ready !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL x0_discard: got ready %0b we %0b want 1/0", lu_ready, rf_we); end
    step();
    idle();
    issue_set = 1; issue_rd = 5'd0;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_not_queued: got %0b want 0", rf_we); end
    step();
    idle();
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL x0_busy0: got %h want 0", busy); end
  endtask

  task automatic test_race();
    issue_set = 1; issue_rd = 5'd4;
    step();
    idle();
    pipe_we = 1; pipe_waddr = 5'd2; pipe_wdata = 32'h2;
    lu_valid = 1; lu_waddr = 5'd4; lu_wdata = 32'h44;
    step();
    idle();
    issue_set = 1; issue_rd = 5'd4;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_din !== 32'h44) begin errors++; $display("FAIL race_drain: got %0b/%0d/%h want 1/4/44", rf_we, rf_waddr, rf_din); end
    step();
    idle();
    checks++; if (busy !== 32'h10) begin errors++; $display("FAIL race_set_wins: got %h want 00000010", busy); end
    lu_valid = 1; lu_waddr = 5'd4; lu_wdata = 32'h45;
    step();
    idle();
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL race_cleanup: got %h want 0", busy); end
  endtask

  task automatic test_reset_mid();
    issue_set = 1; issue_rd = 5'd4;
    step();
    issue_rd = 5'd7;
    step();
    idle();
    pipe_we = 1; pipe_waddr = 5'd1; pipe_wdata = 32'h1;
    lu_valid = 1; lu_waddr = 5'd4; lu_wdata = 32'h4;
    step();
    lu_waddr = 5'd7; lu_wdata = 32'h7;
    step();
    lu_valid = 0;
    #1;
    checks++; if (busy !== 32'h90 || lu_ready !== 1'b0) begin errors++; $display("FAIL rstmid_pre: got %h/%0b want 00000090/0", busy, lu_ready); end
    pipe_we = 0;
    #1;
    rstn = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b0 || lu_ready !== 1'b0 || busy !== 32'd0) begin errors++; $display("FAIL rstmid_assert: got we %0b ready %0b busy %h want 0/0/0", rf_we, lu_ready, busy); end
    step();
    @(negedge clk);
    rstn = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rf_we !== 1'b0 || lu_ready !== 1'b1 || busy !== 32'd0) begin errors++; $display("FAIL rstmid_after_%0d: got we %0b ready %0b busy %h want 0/1/0", i, rf_we, lu_ready, busy); end
      step();
    end
  endtask

  // Model: a FIFO of {addr,data}, a busy vector, and the port priority rules.
  task automatic test_random();
    logic [36:0] q[$];
    logic [4:0]  inflight[$];
    logic [31:0] m_busy;
    logic        e_we, e_ready, acc, from_q, bypass;
    logic [4:0]  e_addr, r;
    logic [31:0] e_data;
    m_busy = 32'd0;
    idle();
    for (int cyc = 0; cyc < 400; cyc++) begin
      r = 5'($urandom_range(0, 31));
      pipe_we = ($urandom_range(0, 2) != 0) && !m_busy[r];
      pipe_waddr = r; pipe_wdata = $urandom;
      r = 5'($urandom_range(1, 31));
      issue_set = ($urandom_range(0, 3) == 0) && !m_busy[r] && inflight.size() < 6;
      issue_rd = r;
      chk_rs1 = 5'($urandom); chk_rs2 = 5'($urandom); chk_rd = 5'($urandom);
      if (!lu_valid) begin
        if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
          lu_valid = 1; lu_waddr = inflight[0]; lu_wdata = $urandom;
        end else if ($urandom_range(0, 15) == 0) begin
          lu_valid = 1; lu_waddr = 5'd0; lu_wdata = $urandom;
        end
      end
      #2;
      e_ready = (q.size() < DEPTH);
      acc = lu_valid && e_ready;
      from_q = 0; bypass = 0;
      e_we = 1; e_addr = 0; e_data = 0;
      if (pipe_we && pipe_waddr != 0) begin e_addr = pipe_waddr; e_data = pipe_wdata; end
      else if (q.size() > 0) begin e_addr = q[0][36:32]; e_data = q[0][31:0]; from_q = 1; end
      else if (acc && lu_waddr != 0) begin e_addr = lu_waddr; e_data = lu_wdata; bypass = 1; end
      else e_we = 0;
      checks++; if (lu_ready !== e_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %0b want %0b", cyc, lu_ready, e_ready); end
      checks++; if (rf_we !== e_we || rf_waddr !== e_addr || rf_din !== e_data) begin errors++; $display("FAIL rnd_port c%0d: got %0b/%0d/%h want %0b/%0d/%h", cyc, rf_we, rf_waddr, rf_din, e_we, e_addr, e_data); end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy c%0d: got %h want %h", cyc, busy, m_busy); end
      checks++; if (stall !== (m_busy[chk_rs1] | m_busy[chk_rs2] | m_busy[chk_rd])) begin errors++; $display("FAIL rnd_stall c%0d: got %0b want %0b", cyc, stall, m_busy[chk_rs1] | m_busy[chk_rs2] | m_busy[chk_rd]); end
      if (from_q || bypass) m_busy[e_addr] = 1'b0;
      if (from_q) void'(q.pop_front());
      if (acc && lu_waddr != 0) begin
        void'(inflight.pop_front());
        if (!bypass) q.push_back({lu_waddr, lu_wdata});
      end
      if (issue_set) begin m_busy[issue_rd] = 1'b1; inflight.push_back(issue_rd); end
      step();
      if (acc) lu_valid = 0;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_conflict();
    test_full();
    test_x0();
    test_race();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and scoreboard for the register file in the rv32i pipeline. It shares the single register-file write port between two sources: the in-order pipeline writeback and a long-latency unit (load/mul/div result path). Long-latency results that lose arbitration wait in a small FIFO. A 32-bit scoreboard tracks destinations with outstanding long-latency results and drives the issue-stage stall.

## Interface

Parameters:
- FIFO_DEPTH, 2, long-latency result buffer entries; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rstn  in  1  reset, asynchronous, active-low.
- pipe_we  in  1  pipeline writeback valid.
- pipe_waddr  in  5  pipeline destination register.
- pipe_wdata  in  32  pipeline writeback data.
- lu_valid  in  1  long-latency result valid.
- lu_waddr  in  5  long-latency destination register.
- lu_wdata  in  32  long-latency result data.
- lu_ready  out  1  long-latency result accepted when lu_valid & lu_ready.
- issue_set  in  1  a long-latency op to issue_rd issues this cycle.
- issue_rd  in  5  destination of the issuing long-latency op.
- chk_rs1, chk_rs2, chk_rd  in  5 each  operands of the instruction in decode.
- stall  out  1  decode instruction must hold.
- busy  out  32  scoreboard, bit n = x n has an outstanding long-latency write.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_din  out  32  register-file write data.

## Operation

- Effective pipeline write: pipe_act = pipe_we & (pipe_waddr != 0). A write to x0 does not occupy the port.
- Effective long-latency write: lu_acc = lu_valid & lu_ready. An accepted result with lu_waddr = 0 is discarded. It is never enqueued or written.
- Port priority, in order:
  1. pipe_act: rf_we=1, rf_waddr/rf_din come from the pipe inputs.
  2. Otherwise, if the FIFO is non-empty: the FIFO head is written and popped.
  3. Otherwise, if lu_acc with nonzero address: bypass, written directly and not enqueued.
  4. Otherwise rf_we=0. rf_waddr and rf_din are 0 when rf_we=0.
- Enqueue: an lu_acc with nonzero address that is not bypassed is pushed to the FIFO tail. Push and pop in the same cycle are both allowed.
- lu_ready = !full. It is a function of registered FIFO count only and does not depend on lu_valid.
- Results are written to the register file in acceptance order.
- Scoreboard:
  - busy[issue_rd] is set on issue_set when issue_rd != 0.
  - busy[a] is cleared when a long-latency write to a (FIFO pop or bypass) drives the port.
  - Same cycle set and clear of the same register: set wins.
  - busy[0] is always 0.
- stall = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd]. This is combinational from registered busy. Upstream guarantees that no issue_set or pipe write targets a busy register while stall is asserted.
- Pipeline write to a busy register is a protocol violation. The behaviour is unspecified, and the simulation assertion fires.

## Timing

- Async reset (rstn low): FIFO emptied, busy=0.
- Outputs while rstn is low: lu_ready=0, stall=0, rf_we=0, rf_waddr=0, rf_din=0.
- After rstn deasserts, lu_ready=1 from the first cycle.
- Reset mid-operation: all buffered results and pending scoreboard bits are lost. No write is issued.
- Output paths are combinational:
  - rf_* are combinational from the current pipe/lu inputs and the FIFO head.
  - Bypass latency is 0 cycles, so the write lands at the same posedge as acceptance.
  - A buffered result is written in the first cycle with pipe_act=0, after all older entries.
- FIFO pointers wrap modulo FIFO_DEPTH. Count is held in log2(FIFO_DEPTH)+1 bits.
  - Full: count=FIFO_DEPTH, lu_ready=0. A producer holding lu_valid is not accepted.
  - Full with pipe_act=0 in the same cycle: the pop frees an entry only for the next cycle. lu_ready does not combinationally rise.
- busy updates at posedge and is visible on stall the next cycle.

## Test plan

- Bypass:
  - Stimulus: idle port, issue_set rd=5, next cycle lu_valid with waddr=5, wdata=0xDEADBEEF.
  - Required: rf_we=1, rf_waddr=5, rf_din=0xDEADBEEF in that cycle, busy[5] 1→0, stall with chk_rs1=5 deasserts the following cycle.
- Conflict:
  - Stimulus: pipe_we to x3 (0x11) and lu result x7 (0x22) in the same cycle, pipe_we=0 next cycle.
  - Required: x3 written in cycle 0, x7 written in cycle 1 from the FIFO.
- Full:
  - Stimulus: pipe_we held to x1 for 4 cycles, lu_valid held with results A, B, C.
  - Required: A and B accepted, lu_ready=0 from cycle 2, C held. After pipe_we drops, A, B, then C written in order.
- x0:
  - Stimulus: pipe_we to x0 and lu result to x9 in the same cycle.
  - Required: x9 is bypassed and written. Separately, lu result to x0 is accepted with rf_we=0, and busy[0] stays 0 after issue_set rd=0.
- Set/clear race:
  - Stimulus: issue_set rd=4 in the same cycle a buffered x4 result drains.
  - Required: busy[4]=1 afterwards.
- Reset mid-operation:
  - Stimulus: FIFO holding 2 entries, busy=0x0000_0090, rstn pulsed low mid-cycle.
  - Required: immediate rf_we=0, lu_ready=0. After release busy=0, FIFO empty, no stale writes.
